// File: rtl/jtag_pkg.sv
// Shared constants, FSM state and DR payload types for the virtual-JTAG register master.
package jtag_pkg;

    localparam int unsigned DRW    = 40;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 6;

    localparam logic [1:0] IR_NOP   = 2'b00;
    localparam logic [1:0] IR_WRITE = 2'b01;
    localparam logic [1:0] IR_READ  = 2'b10;

    localparam logic [ADDR_W-1:0] REG_CONTROL  = 8'h00;
    localparam logic [ADDR_W-1:0] REG_IN_W     = 8'h01;
    localparam logic [ADDR_W-1:0] REG_IN_H     = 8'h02;
    localparam logic [ADDR_W-1:0] REG_SCALE    = 8'h03;
    localparam logic [ADDR_W-1:0] REG_STATUS   = 8'h10;
    localparam logic [ADDR_W-1:0] REG_IN_ADDR  = 8'h20;
    localparam logic [ADDR_W-1:0] REG_IN_DATA  = 8'h21;
    localparam logic [ADDR_W-1:0] REG_OUT_ADDR = 8'h30;
    localparam logic [ADDR_W-1:0] REG_OUT_DATA = 8'h31;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CAPTURE,
        ST_SHIFT,
        ST_UPDATE,
        ST_TAIL,
        ST_RESP
    } state_t;

    // DR image as shifted LSB first: address in the low byte, data above it.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
    } dr_t;

endpackage

// File: rtl/jtag_reg_master_if.sv
// Command/response port plus the bit-level JTAG pins of the register master.
interface jtag_reg_master_if;
    import jtag_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_is_read;
    logic [DATA_W-1:0] rsp_rdata;
    logic              tck;
    logic              tdi;
    logic              tdo;
    logic [1:0]        ir_in;
    logic              vs_cdr;
    logic              vs_sdr;
    logic              vs_udr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, tdo,
        output cmd_ready, rsp_valid, rsp_is_read, rsp_rdata,
        output tck, tdi, ir_in, vs_cdr, vs_sdr, vs_udr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, tdo,
        input  cmd_ready, rsp_valid, rsp_is_read, rsp_rdata,
        input  tck, tdi, ir_in, vs_cdr, vs_sdr, vs_udr
    );

endinterface

// File: rtl/jtag_tck_gen.sv
// tck divider: toggles every TCK_DIV clk_sys cycles while enabled, with edge strobes.
module jtag_tck_gen #(
    parameter int unsigned TCK_DIV = 4
) (
    input  logic clk_sys,
    input  logic rst_sys_n,
    input  logic en_i,
    output logic tck_o,
    output logic rise_en_c_o,
    output logic fall_en_c_o
);

    localparam int unsigned       DIV_W    = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TCK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tck_q, tck_d;
    logic             term_c;

    // Strobes are high in the clk_sys cycle whose closing edge moves tck.
    assign term_c      = en_i && (div_q == DIV_LAST);
    assign rise_en_c_o = term_c && !tck_q;
    assign fall_en_c_o = term_c && tck_q;
    assign tck_o       = tck_q;

    // Divider count and tck toggle; disabled means parked low with a fresh count.
    always_comb begin
        div_d = div_q;
        tck_d = tck_q;
        if (!en_i) begin
            div_d = '0;
            tck_d = 1'b0;
        end else if (term_c) begin
            div_d = '0;
            tck_d = !tck_q;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Divider registers.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            div_q <= '0;
            tck_q <= 1'b0;
        end else begin
            div_q <= div_d;
            tck_q <= tck_d;
        end
    end

endmodule

// File: rtl/jtag_reg_master.sv
// Turns single register write/read commands into virtual-JTAG DR phases and collects tdo.
module jtag_reg_master #(
    parameter int unsigned DRW      = jtag_pkg::DRW,
    parameter int unsigned TCK_DIV  = 4,
    parameter int unsigned IDLE_TCK = 4
) (
    input  logic               clk_sys,
    input  logic               rst_sys_n,
    jtag_reg_master_if.master  bus_io
);
    import jtag_pkg::*;

    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(DRW - 1);
    localparam logic [CNT_W-1:0] TAIL_LAST  = CNT_W'(IDLE_TCK - 1);

    state_t            state_q, state_d;
    logic              is_read_q, is_read_d;
    logic              phase2_q, phase2_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DRW-1:0]    sr_q, sr_d;

    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_is_read_q, rsp_is_read_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              tdi_q, tdi_d;
    logic [1:0]        ir_q, ir_d;
    logic              cdr_q, cdr_d;
    logic              sdr_q, sdr_d;
    logic              udr_q, udr_d;

    logic              tck_en_c;
    logic              tck_w;
    logic              rise_c;
    logic              fall_c;
    logic              accept_c;
    logic              upd_c;
    dr_t               dr_load_c;

    assign accept_c = bus_io.cmd_valid && cmd_ready_q;
    assign tck_en_c = (state_q != ST_IDLE) && (state_q != ST_RESP);

    jtag_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk_sys     (clk_sys),
        .rst_sys_n   (rst_sys_n),
        .en_i        (tck_en_c),
        .tck_o       (tck_w),
        .rise_en_c_o (rise_c),
        .fall_en_c_o (fall_c)
    );

    // State register.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: every tck-phase step happens on the falling-edge strobe.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (accept_c) state_d = ST_SETUP;
            ST_SETUP:   if (fall_c) state_d = ST_CAPTURE;
            ST_CAPTURE: if (fall_c) state_d = ST_SHIFT;
            ST_SHIFT:   if (fall_c && (cnt_q == SHIFT_LAST)) state_d = ST_UPDATE;
            ST_UPDATE:  if (fall_c) state_d = ST_TAIL;
            ST_TAIL: begin
                if (fall_c && (cnt_q == TAIL_LAST)) begin
                    state_d = (is_read_q && !phase2_q) ? ST_SETUP : ST_RESP;
                end
            end
            ST_RESP:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Datapath and pin values; pins only move on tck falls or outside the tck phases.
    always_comb begin
        is_read_d     = is_read_q;
        phase2_d      = phase2_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        cnt_d         = cnt_q;
        sr_d          = sr_q;
        cmd_ready_d   = cmd_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_is_read_d = rsp_is_read_q;
        rsp_rdata_d   = rsp_rdata_q;
        tdi_d         = tdi_q;
        ir_d          = ir_q;
        cdr_d         = cdr_q;
        sdr_d         = sdr_q;
        udr_d         = udr_q;
        upd_c         = fall_c || (state_q == ST_IDLE) || (state_q == ST_RESP);

        dr_load_c.data = is_read_q ? '0 : wdata_q;
        dr_load_c.addr = addr_q;

        if (accept_c) begin
            is_read_d = !bus_io.cmd_write;
            phase2_d  = 1'b0;
            addr_d    = bus_io.cmd_addr;
            wdata_d   = bus_io.cmd_wdata;
        end

        if ((state_q == ST_TAIL) && (state_d == ST_SETUP)) begin
            phase2_d = 1'b1;
        end

        // Period counter restarts on every state change, counts periods within SHIFT/TAIL.
        if (fall_c) begin
            cnt_d = (state_d == state_q) ? cnt_q + CNT_W'(1) : '0;
        end

        // DR image loads at CAPTURE entry; tdo enters at the MSB on each SHIFT rise.
        if (fall_c && (state_d == ST_CAPTURE)) begin
            sr_d = DRW'(dr_load_c);
        end else if (rise_c && (state_q == ST_SHIFT)) begin
            sr_d = {bus_io.tdo, sr_q[DRW-1:1]};
        end

        if (upd_c) begin
            cmd_ready_d   = (state_d == ST_IDLE);
            rsp_valid_d   = (state_d == ST_RESP);
            rsp_is_read_d = (state_d == ST_RESP) && is_read_q;
            cdr_d         = (state_d == ST_CAPTURE);
            sdr_d         = (state_d == ST_SHIFT);
            udr_d         = (state_d == ST_UPDATE);
            tdi_d         = (state_d == ST_SHIFT) ? sr_q[0] : 1'b0;
            if (state_d == ST_IDLE) begin
                ir_d = IR_NOP;
            end else begin
                ir_d = is_read_d ? IR_READ : IR_WRITE;
            end
            if ((state_d == ST_RESP) && is_read_q) begin
                rsp_rdata_d = sr_q[ADDR_W +: DATA_W];
            end
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            is_read_q     <= 1'b0;
            phase2_q      <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            cnt_q         <= '0;
            sr_q          <= '0;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_is_read_q <= 1'b0;
            rsp_rdata_q   <= '0;
            tdi_q         <= 1'b0;
            ir_q          <= IR_NOP;
            cdr_q         <= 1'b0;
            sdr_q         <= 1'b0;
            udr_q         <= 1'b0;
        end else begin
            is_read_q     <= is_read_d;
            phase2_q      <= phase2_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            cnt_q         <= cnt_d;
            sr_q          <= sr_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_is_read_q <= rsp_is_read_d;
            rsp_rdata_q   <= rsp_rdata_d;
            tdi_q         <= tdi_d;
            ir_q          <= ir_d;
            cdr_q         <= cdr_d;
            sdr_q         <= sdr_d;
            udr_q         <= udr_d;
        end
    end

    assign bus_io.cmd_ready   = cmd_ready_q;
    assign bus_io.rsp_valid   = rsp_valid_q;
    assign bus_io.rsp_is_read = rsp_is_read_q;
    assign bus_io.rsp_rdata   = rsp_rdata_q;
    assign bus_io.tck         = tck_w;
    assign bus_io.tdi         = tdi_q;
    assign bus_io.ir_in       = ir_q;
    assign bus_io.vs_cdr      = cdr_q;
    assign bus_io.vs_sdr      = sdr_q;
    assign bus_io.vs_udr      = udr_q;

endmodule

// File: tb/tb_jtag_reg_master.sv
// Directed bench: master driving a small behavioural register responder.
module tb_jtag_reg_master;
    import jtag_pkg::*;

    logic clk_sys   = 1'b0;
    logic rst_sys_n = 1'b0;
    int   n_chk     = 0;
    int   n_pass    = 0;

    always #5 clk_sys = ~clk_sys;

    jtag_reg_master_if bus_if ();
    jtag_reg_master_if bus1_if ();

    jtag_reg_master #(.DRW(40), .TCK_DIV(4), .IDLE_TCK(4)) dut (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .bus_io    (bus_if)
    );

    jtag_reg_master #(.DRW(40), .TCK_DIV(1), .IDLE_TCK(4)) dut_fast (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .bus_io    (bus1_if)
    );

    // Responder model: DR shifts on tck rise, LSB out on tdo.
    logic [39:0] r_dr      = '0;
    logic [7:0]  r_raddr   = '0;
    logic [31:0] r_in_w    = '0;
    logic [31:0] r_scale   = 32'h0000_00CD;
    logic [31:0] r_in_addr = '0;
    logic [31:0] bram [0:15];
    int          udr_cnt   = 0;
    int          sdr_cnt   = 0;

    function automatic logic [31:0] rsp_read(input logic [7:0] a);
        case (a)
            8'h01:   return r_in_w;
            8'h03:   return r_scale;
            8'h10:   return 32'h0000_0001;
            8'h20:   return r_in_addr;
            8'h21:   return bram[r_in_addr[3:0]];
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(posedge bus_if.tck) begin
        if (bus_if.vs_cdr) begin
            r_dr    <= {rsp_read(r_raddr), r_raddr};
            sdr_cnt <= 0;
        end else if (bus_if.vs_sdr) begin
            r_dr    <= {bus_if.tdi, r_dr[39:1]};
            sdr_cnt <= sdr_cnt + 1;
        end else if (bus_if.vs_udr) begin
            udr_cnt <= udr_cnt + 1;
            if (bus_if.ir_in == IR_WRITE) begin
                case (r_dr[7:0])
                    8'h01:   r_in_w    <= r_dr[39:8];
                    8'h03:   r_scale   <= r_dr[39:8];
                    8'h20:   r_in_addr <= r_dr[39:8];
                    default: ;
                endcase
            end else if (bus_if.ir_in == IR_READ) begin
                r_raddr <= r_dr[7:0];
            end
        end
    end

    assign bus_if.tdo  = r_dr[0];
    assign bus1_if.tdo = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Issue one command from a negedge; returns at the negedge where rsp_valid is seen.
    task automatic run_cmd(input logic w, input logic [7:0] a, input logic [31:0] d,
                           input bit keep, output int acc_wait, output int lat,
                           output logic [31:0] rdata, output logic isrd,
                           output logic [1:0] ir_mid, output logic rdy_mid);
        bus_if.cmd_write = w;
        bus_if.cmd_addr  = a;
        bus_if.cmd_wdata = d;
        bus_if.cmd_valid = 1'b1;
        acc_wait = 0;
        while (!bus_if.cmd_ready && acc_wait < 50) begin
            @(negedge clk_sys);
            acc_wait++;
        end
        @(negedge clk_sys);
        if (!keep) bus_if.cmd_valid = 1'b0;
        lat     = 1;
        ir_mid  = 2'b11;
        rdy_mid = 1'b1;
        while (!bus_if.rsp_valid && lat < 2000) begin
            if (lat == 20) begin
                ir_mid  = bus_if.ir_in;
                rdy_mid = bus_if.cmd_ready;
            end
            @(negedge clk_sys);
            lat++;
        end
        rdata = bus_if.rsp_rdata;
        isrd  = bus_if.rsp_is_read;
    endtask

    initial begin
        int          aw, lat, g, udr_before;
        logic [31:0] rd;
        logic        isrd, rdy;
        logic [1:0]  irm;

        for (int i = 0; i < 16; i++) bram[i] = 32'h0000_0000;
        bram[5] = 32'h0000_00A7;
        bus_if.cmd_valid  = 1'b0;
        bus_if.cmd_write  = 1'b0;
        bus_if.cmd_addr   = '0;
        bus_if.cmd_wdata  = '0;
        bus1_if.cmd_valid = 1'b0;
        bus1_if.cmd_write = 1'b0;
        bus1_if.cmd_addr  = '0;
        bus1_if.cmd_wdata = '0;

        repeat (3) @(negedge clk_sys);
        check("rst_ready", 32'(bus_if.cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        check("rst_tck_tdi", 32'({bus_if.tck, bus_if.tdi}), 32'd0);
        check("rst_ir", 32'(bus_if.ir_in), 32'd0);
        check("rst_vs", 32'({bus_if.vs_cdr, bus_if.vs_sdr, bus_if.vs_udr}), 32'd0);
        check("rst_rdata", bus_if.rsp_rdata, 32'd0);
        rst_sys_n = 1'b1;
        @(negedge clk_sys);

        // Read SCALE reset value.
        run_cmd(1'b0, 8'h03, 32'h0, 1'b0, aw, lat, rd, isrd, irm, rdy);
        check("rd03_lat", 32'(lat), 32'd753);
        check("rd03_data", rd, 32'h0000_00CD);
        check("rd03_isrd", 32'(isrd), 32'd1);
        check("rd03_ir_mid", 32'(irm), 32'd2);
        check("rd03_busy_ready", 32'(rdy), 32'd0);
        @(negedge clk_sys);
        check("rsp_pulse_len", 32'(bus_if.rsp_valid), 32'd0);
        check("idle_ir", 32'(bus_if.ir_in), 32'd0);
        check("idle_ready", 32'(bus_if.cmd_ready), 32'd1);

        // Write IN_W.
        run_cmd(1'b1, 8'h01, 32'h0000_0080, 1'b0, aw, lat, rd, isrd, irm, rdy);
        check("wr01_lat", 32'(lat), 32'd377);
        check("wr01_isrd", 32'(isrd), 32'd0);
        check("wr01_ir_mid", 32'(irm), 32'd1);
        check("wr01_rdata_held", rd, 32'h0000_00CD);
        check("wr01_resp_reg", r_in_w, 32'h0000_0080);
        @(negedge clk_sys);

        // Unmapped and status reads.
        run_cmd(1'b0, 8'h55, 32'h0, 1'b0, aw, lat, rd, isrd, irm, rdy);
        check("rd55_data", rd, 32'hDEAD_BEEF);
        @(negedge clk_sys);
        run_cmd(1'b0, 8'h10, 32'h0, 1'b0, aw, lat, rd, isrd, irm, rdy);
        check("rd10_data", rd, 32'h0000_0001);
        @(negedge clk_sys);

        // Back-to-back: write IN_ADDR then read IN_DATA with cmd_valid held.
        run_cmd(1'b1, 8'h20, 32'h0000_0005, 1'b1, aw, lat, rd, isrd, irm, rdy);
        check("wr20_lat", 32'(lat), 32'd377);
        run_cmd(1'b0, 8'h21, 32'h0, 1'b0, aw, lat, rd, isrd, irm, rdy);
        check("b2b_accept_gap", 32'(aw), 32'd1);
        check("rd21_lat", 32'(lat), 32'd753);
        check("rd21_data", rd, 32'h0000_00A7);
        @(negedge clk_sys);

        // Full 32-bit data path round trip.
        run_cmd(1'b1, 8'h03, 32'hA5C3_0F01, 1'b0, aw, lat, rd, isrd, irm, rdy);
        check("wr03_resp_reg", r_scale, 32'hA5C3_0F01);
        @(negedge clk_sys);
        run_cmd(1'b0, 8'h03, 32'h0, 1'b0, aw, lat, rd, isrd, irm, rdy);
        check("rd03b_data", rd, 32'hA5C3_0F01);
        @(negedge clk_sys);

        // Reset in the middle of SHIFT.
        udr_before       = udr_cnt;
        bus_if.cmd_write = 1'b1;
        bus_if.cmd_addr  = 8'h01;
        bus_if.cmd_wdata = 32'h0000_1234;
        bus_if.cmd_valid = 1'b1;
        @(negedge clk_sys);
        bus_if.cmd_valid = 1'b0;
        g = 0;
        while (!(bus_if.vs_sdr && sdr_cnt >= 20) && g < 2000) begin
            @(negedge clk_sys);
            g++;
        end
        check("mid_reached_shift20", 32'(g < 2000), 32'd1);
        rst_sys_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(bus_if.cmd_ready), 32'd1);
        check("mid_rst_tck_tdi", 32'({bus_if.tck, bus_if.tdi}), 32'd0);
        check("mid_rst_vs", 32'({bus_if.vs_cdr, bus_if.vs_sdr, bus_if.vs_udr}), 32'd0);
        check("mid_rst_ir", 32'(bus_if.ir_in), 32'd0);
        check("mid_rst_rdata", bus_if.rsp_rdata, 32'd0);
        repeat (2) @(negedge clk_sys);
        rst_sys_n = 1'b1;
        repeat (20) @(negedge clk_sys);
        check("mid_no_update", 32'(udr_cnt - udr_before), 32'd0);
        check("mid_resp_reg", r_in_w, 32'h0000_0080);
        run_cmd(1'b0, 8'h01, 32'h0, 1'b0, aw, lat, rd, isrd, irm, rdy);
        check("rd01_after_rst", rd, 32'h0000_0080);
        @(negedge clk_sys);

        // TCK_DIV = 1 write latency.
        bus1_if.cmd_write = 1'b1;
        bus1_if.cmd_addr  = 8'h01;
        bus1_if.cmd_wdata = 32'h0000_0001;
        bus1_if.cmd_valid = 1'b1;
        @(negedge clk_sys);
        bus1_if.cmd_valid = 1'b0;
        lat = 1;
        while (!bus1_if.rsp_valid && lat < 500) begin
            @(negedge clk_sys);
            lat++;
        end
        check("fast_wr_lat", 32'(lat), 32'd95);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
